rect_fill_arbiter: RTL
======================

RECT_FILL_ARBITER -- requirements
Module: rect_fill_arbiter

Interface
REQ-001 SHALL have parameter XMAX, default 159, meaning last visible screen column.
REQ-002 SHALL have parameter YMAX, default 119, meaning last visible screen row.
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  3  per-requester fill request; bit i belongs to requester i.
REQ-006 SHALL have port rx0  input  24  rectangle left x, 8 bits per requester; requester i uses [8i+7:8i].
REQ-007 SHALL have port ry0  input  21  rectangle top y, 7 bits per requester.
REQ-008 SHALL have port rw  input  24  rectangle width, 8 bits per requester.
REQ-009 SHALL have port rh  input  21  rectangle height, 7 bits per requester.
REQ-010 SHALL have port rcolor  input  9  fill colour, 3 bits per requester.
REQ-011 SHALL have port ack  output  3  one-cycle pulse: that requester's command has been accepted.
REQ-012 SHALL have port done  output  3  one-cycle pulse: that requester's fill is complete.
REQ-013 SHALL have port busy  output  1  high from acceptance through the done cycle.
REQ-014 SHALL have port x  output  8  pixel column to the frame writer.
REQ-015 SHALL have port y  output  7  pixel row to the frame writer.
REQ-016 SHALL have port plot  output  1  pixel write strobe.
REQ-017 SHALL have port color  output  3  pixel colour.

Function
REQ-018 SHALL implement states IDLE, FILL and DONE; all outputs SHALL be registered.
REQ-019 SHALL, in IDLE with any req bit high at an edge, grant by round-robin starting at pointer p; grant goes to the first set bit in order p, p+1, p+2 (mod 3).
REQ-020 SHALL, at the grant edge: latch the granted requester's x0/y0/w/h/colour; set ack[g]=1 for exactly the next cycle; set busy=1; set p=(g+1) mod 3; load cx=x0, cy=y0; enter FILL.
REQ-021 SHALL ignore requester parameter changes after the grant edge; a requester holds req and parameters until it sees ack.
REQ-022 SHALL, if latched w==0 or h==0, skip FILL and enter DONE directly; no plot is issued.
REQ-023 SHALL, at each FILL edge, drive x=cx[7:0], y=cy[6:0], color=latched colour, plot=(cx<=XMAX && cy<=YMAX); then advance the scan.
REQ-024 SHALL scan x fastest: cx increments until cx==x0+w-1, then cx=x0 and cy increments; after the pixel (x0+w-1, y0+h-1) it enters DONE.
REQ-025 SHALL keep cx at 9 bits and cy at 8 bits so x0+w and y0+h never wrap.
REQ-026 SHALL still consume a scan cycle for an off-screen (clipped) pixel, with plot=0; the fill always takes exactly w*h FILL cycles.
REQ-027 SHALL place the first pixel on the outputs 2 cycles after the request-sampling edge, with consecutive pixels on consecutive cycles.
REQ-028 SHALL, on the DONE edge: drive plot=0; pulse done[g] for one cycle; and then set busy=0 and return to IDLE.
REQ-029 SHALL allow a new grant on the edge after DONE; the earliest back-to-back gap is 1 idle cycle.
REQ-030 SHALL hold plot=0 in IDLE; x, y and color SHALL hold their last values.
REQ-031 SHALL never assert more than one ack bit or one done bit per cycle.

Reset
REQ-032 SHALL, with reset high at an edge, force: state IDLE; x=0, y=0, plot=0, color=0; ack=0, done=0, busy=0; p=0.
REQ-033 SHALL abort any fill in progress on reset (mid-FILL included) without pulsing done; reset takes priority over all other events.

Verification
REQ-034 Single requester 0, x0=10, y0=5, w=3, h=2, colour=6 -> ack0 for 1 cycle; plot=1 for 6 cycles at (10,5), (11,5), (12,5), (10,6), (11,6), (12,6) with colour 6; then done0 for 1 cycle; busy low after.
REQ-035 All three req held from reset, each w=1, h=1 -> grants in order 0,1,2,0,1,2; each grant gives exactly 1 plot cycle and 1 done pulse.
REQ-036 Clip, x0=158, y0=119, w=4, h=2 -> 8 FILL cycles; plot=1 only at (158,119) and (159,119); done one cycle after the 8th scan cycle.
REQ-037 Zero size, w=0, h=5 -> ack pulse, no plot, done pulse 2 cycles after the request edge.
REQ-038 Reset asserted on the 3rd pixel of a 4x4 fill -> next cycle plot=0, busy=0, no done; a request from requester 2 afterwards is granted with p=0 semantics.

Source files
------------

// File: rtl/rect_fill_arbiter_if.sv
// rtl/rect_fill_arbiter_if.sv - requester/frame-writer bundle for the rectangle fill arbiter
// Three requesters share the command lanes; the arbiter side is the slave modport.
interface rect_fill_arbiter_if;
   logic [2:0]  req;
   logic [23:0] rx0;
   logic [20:0] ry0;
   logic [23:0] rw;
   logic [20:0] rh;
   logic [8:0]  rcolor;
   logic [2:0]  ack;
   logic [2:0]  done;
   logic        busy;
   logic [7:0]  x;
   logic [6:0]  y;
   logic        plot;
   logic [2:0]  color;

   modport slave (
      input  req, rx0, ry0, rw, rh, rcolor,
      output ack, done, busy, x, y, plot, color
   );

   modport master (
      output req, rx0, ry0, rw, rh, rcolor,
      input  ack, done, busy, x, y, plot, color
   );
endinterface

// File: rtl/rect_fill_arbiter.sv
// rtl/rect_fill_arbiter.sv - round-robin arbiter that scans one granted rectangle into pixel writes
// Scan counters are one bit wider than the screen so x0+w and y0+h never wrap.
module rect_fill_arbiter #(
   parameter int XMAX = 159,
   parameter int YMAX = 119
) (
   input logic                clk,
   input logic                reset,
   rect_fill_arbiter_if.slave bus
);
   localparam logic [8:0] XLIM = 9'(XMAX);
   localparam logic [7:0] YLIM = 8'(YMAX);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_ptr;
   logic [1:0]  r_gnt;
   logic [1:0]  w_gnt;
   logic        w_any;
   logic        w_zero;
   logic        w_last;
   logic [7:0]  w_x0;
   logic [6:0]  w_y0;
   logic [7:0]  w_w;
   logic [6:0]  w_h;
   logic [2:0]  w_col;
   logic [7:0]  r_x0;
   logic [8:0]  r_xend;
   logic [7:0]  r_yend;
   logic [8:0]  r_cx;
   logic [7:0]  r_cy;
   logic [2:0]  r_col;
   logic [2:0]  r_ack;
   logic [2:0]  r_done;
   logic        r_busy;
   logic [7:0]  r_x;
   logic [6:0]  r_y;
   logic        r_plot;
   logic [2:0]  r_color;

   assign w_any  = |bus.req;
   assign w_zero = (w_w == 8'd0) || (w_h == 7'd0);
   assign w_last = (r_cx == r_xend) && (r_cy == r_yend);

   // First set request bit searching upward (mod 3) from the pointer.
   always_comb begin
      w_gnt = 2'd0;
      case (r_ptr)
         2'd1:    w_gnt = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
         2'd2:    w_gnt = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
         default: w_gnt = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      w_x0  = bus.rx0[7:0];
      w_y0  = bus.ry0[6:0];
      w_w   = bus.rw[7:0];
      w_h   = bus.rh[6:0];
      w_col = bus.rcolor[2:0];
      case (w_gnt)
         2'd1: begin
            w_x0  = bus.rx0[15:8];
            w_y0  = bus.ry0[13:7];
            w_w   = bus.rw[15:8];
            w_h   = bus.rh[13:7];
            w_col = bus.rcolor[5:3];
         end
         2'd2: begin
            w_x0  = bus.rx0[23:16];
            w_y0  = bus.ry0[20:14];
            w_w   = bus.rw[23:16];
            w_h   = bus.rh[20:14];
            w_col = bus.rcolor[8:6];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = w_zero ? S_DONE : S_FILL;
         S_FILL:  if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr   <= 2'd0;
         r_gnt   <= 2'd0;
         r_x0    <= 8'd0;
         r_xend  <= 9'd0;
         r_yend  <= 8'd0;
         r_cx    <= 9'd0;
         r_cy    <= 8'd0;
         r_col   <= 3'd0;
         r_ack   <= 3'd0;
         r_done  <= 3'd0;
         r_busy  <= 1'b0;
         r_x     <= 8'd0;
         r_y     <= 7'd0;
         r_plot  <= 1'b0;
         r_color <= 3'd0;
      end else begin
         r_ack  <= 3'd0;
         r_done <= 3'd0;
         r_plot <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_busy <= 1'b0;
               if (w_any) begin
                  r_gnt  <= w_gnt;
                  r_ptr  <= (w_gnt == 2'd2) ? 2'd0 : w_gnt + 2'd1;
                  r_ack  <= 3'b001 << w_gnt;
                  r_busy <= 1'b1;
                  r_x0   <= w_x0;
                  r_col  <= w_col;
                  r_cx   <= {1'b0, w_x0};
                  r_cy   <= {1'b0, w_y0};
                  r_xend <= {1'b0, w_x0} + {1'b0, w_w} - 9'd1;
                  r_yend <= {1'b0, w_y0} + {1'b0, w_h} - 8'd1;
               end
            end
            S_FILL: begin
               r_x     <= r_cx[7:0];
               r_y     <= r_cy[6:0];
               r_color <= r_col;
               r_plot  <= (r_cx <= XLIM) && (r_cy <= YLIM);
               if (r_cx == r_xend) begin
                  r_cx <= {1'b0, r_x0};
                  r_cy <= r_cy + 8'd1;
               end else begin
                  r_cx <= r_cx + 9'd1;
               end
            end
            S_DONE: r_done <= 3'b001 << r_gnt;
            default: ;
         endcase
      end
   end

   assign bus.ack   = r_ack;
   assign bus.done  = r_done;
   assign bus.busy  = r_busy;
   assign bus.x     = r_x;
   assign bus.y     = r_y;
   assign bus.plot  = r_plot;
   assign bus.color = r_color;
endmodule
